// File: rtl/fixed_pt_dot_accumulator_if.sv
// Handshake bundle between fixed_pt_multiplier products and the dot-product result consumer.
// The slave modport is the accumulator view. The master modport is the producer/consumer view.
interface fixed_pt_dot_accumulator_if #(
   parameter int W  = 24,
   parameter int CW = 8
);
   logic          in_valid;
   logic          in_ready;
   logic          in_last;
   logic [W-1:0]  product;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  sum;
   logic [CW-1:0] count;
   logic          overflow;

   modport slave (
      input  in_valid, in_last, product, out_ready,
      output in_ready, out_valid, sum, count, overflow
   );

   modport master (
      output in_valid, in_last, product, out_ready,
      input  in_ready, out_valid, sum, count, overflow
   );
endinterface

// File: rtl/fixed_pt_dot_accumulator.sv
// Sums a vector of signed Q(W-1-D).D products into a W-bit saturated dot product, plus a count and an overflow flag.
// Latency: the result is valid one cycle after the last beat is accepted.
// Backpressure: in_ready is held low while a result waits for out_ready.
module fixed_pt_dot_accumulator #(
   parameter int OPERAND_WIDTH = 24,
   parameter int DECIMAL_PLACE = 8,
   parameter int GUARD_BITS    = 8,
   parameter int COUNT_WIDTH   = 8
) (
   input logic                    clk,
   input logic                    rst,
   fixed_pt_dot_accumulator_if.slave bus
);
   localparam int W = OPERAND_WIDTH;
   localparam int A = OPERAND_WIDTH + GUARD_BITS;
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [0:0] {ACCUM, HOLD} state_t;

   state_t                 state_q, state_d;
   logic [A-1:0]           acc_q, acc_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                   cnt_sat_q, cnt_sat_d;
   logic [W-1:0]           sum_q, sum_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   ovf_q, ovf_d;
   logic                   out_vld_q, out_vld_d;

   logic                   accept;
   logic [A-1:0]           total;
   logic [A-W:0]           total_top;
   logic                   in_range;
   logic [W-1:0]           total_sat;
   logic [COUNT_WIDTH-1:0] cnt_inc;
   logic                   cnt_hit;

   assign bus.in_ready = (state_q == ACCUM) && !rst;
   assign accept       = bus.in_valid && bus.in_ready;

   assign total     = acc_q + {{GUARD_BITS{bus.product[W-1]}}, bus.product};
   // The total fits in W signed bits only when every bit from W-1 upward matches the sign.
   assign total_top = total[A-1:W-1];
   assign in_range  = (&total_top) || !(|total_top);
   assign total_sat = in_range ? total[W-1:0] :
                      (total[A-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});

   assign cnt_inc = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + COUNT_WIDTH'(1);
   assign cnt_hit = (cnt_inc == CNT_MAX);

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      cnt_sat_d = cnt_sat_q;
      sum_d     = sum_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      out_vld_d = out_vld_q;
      case (state_q)
         ACCUM: begin
            if (accept) begin
               if (!bus.in_last) begin
                  acc_d     = total;
                  cnt_d     = cnt_inc;
                  cnt_sat_d = cnt_sat_q || cnt_hit;
               end else begin
                  sum_d     = total_sat;
                  count_d   = cnt_inc;
                  ovf_d     = !in_range || cnt_sat_q || cnt_hit;
                  out_vld_d = 1'b1;
                  acc_d     = '0;
                  cnt_d     = '0;
                  cnt_sat_d = 1'b0;
                  state_d   = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_vld_q && bus.out_ready) begin
               out_vld_d = 1'b0;
               state_d   = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ACCUM;
         acc_q     <= '0;
         cnt_q     <= '0;
         cnt_sat_q <= 1'b0;
         sum_q     <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
         out_vld_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         cnt_sat_q <= cnt_sat_d;
         sum_q     <= sum_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         out_vld_q <= out_vld_d;
      end
   end

   // Outputs read as cleared during any reset cycle, not only after the reset edge.
   assign bus.out_valid = out_vld_q && !rst;
   assign bus.sum       = rst ? '0 : sum_q;
   assign bus.count     = rst ? '0 : count_q;
   assign bus.overflow  = ovf_q && !rst;
endmodule

// File: tb/tb_fixed_pt_dot_accumulator.sv
// Directed bench for fixed_pt_dot_accumulator: hand-computed dot products, saturation, backpressure, count limit, reset.
module tb_fixed_pt_dot_accumulator;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   fixed_pt_dot_accumulator_if #(.W(24), .CW(8)) bus ();

   fixed_pt_dot_accumulator #(
      .OPERAND_WIDTH(24),
      .DECIMAL_PLACE(8),
      .GUARD_BITS(8),
      .COUNT_WIDTH(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [23:0] p, input logic l);
      int n;
      n = 0;
      bus.in_valid = 1'b1;
      bus.product  = p;
      bus.in_last  = l;
      while (!bus.in_ready && n < 20) begin
         tick();
         n++;
      end
      if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
      else tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic expect_result(input string tag, input logic [23:0] s, input logic [7:0] c, input logic o);
      chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_sum"}, 32'(bus.sum), 32'(s));
      chk({tag, "_cnt"}, 32'(bus.count), 32'(c));
      chk({tag, "_ovf"}, 32'(bus.overflow), 32'(o));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_last   = 1'b0;
      bus.product   = '0;
      bus.out_ready = 1'b0;
      tick();
      tick();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_sum", 32'(bus.sum), 32'd0);
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_ovf", 32'(bus.overflow), 32'd0);
      rst = 1'b0;
      #1;
      chk("idle_in_ready", 32'(bus.in_ready), 32'd1);

      // 1.0 + 2.5 - 1.0 = 2.5
      send(24'h000100, 1'b0);
      send(24'h000280, 1'b0);
      send(24'hFFFF00, 1'b1);
      expect_result("v3", 24'h000280, 8'd3, 1'b0);

      send(24'h000123, 1'b1);
      expect_result("single", 24'h000123, 8'd1, 1'b0);

      send(24'h7FFFFF, 1'b0);
      send(24'h7FFFFF, 1'b1);
      expect_result("satpos", 24'h7FFFFF, 8'd2, 1'b1);

      send(24'h800000, 1'b0);
      send(24'h800000, 1'b1);
      expect_result("satneg", 24'h800000, 8'd2, 1'b1);

      send(24'h7FFFFF, 1'b0);
      send(24'h000100, 1'b0);
      send(24'hFFFE00, 1'b1);
      expect_result("guard", 24'h7FFEFF, 8'd3, 1'b0);

      // Backpressure: result held while a new beat waits
      send(24'h000010, 1'b1);
      bus.in_valid = 1'b1;
      bus.product  = 24'h000040;
      bus.in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
         chk("bp_vld", 32'(bus.out_valid), 32'd1);
         chk("bp_sum", 32'(bus.sum), 32'h10);
         chk("bp_cnt", 32'(bus.count), 32'd1);
         tick();
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("bp_release_vld", 32'(bus.out_valid), 32'd0);
      chk("bp_release_rdy", 32'(bus.in_ready), 32'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      expect_result("bp_next", 24'h000040, 8'd1, 1'b0);

      // 254 beats: count just below the limit
      for (int i = 0; i < 253; i++) send(24'h000001, 1'b0);
      send(24'h000001, 1'b1);
      expect_result("cnt254", 24'h0000FE, 8'd254, 1'b0);

      // 255 beats: count reaches its maximum, flagged as overflow
      for (int i = 0; i < 254; i++) send(24'h000001, 1'b0);
      send(24'h000001, 1'b1);
      expect_result("cnt255", 24'h0000FF, 8'd255, 1'b1);

      // Reset mid-vector discards the partial sum
      send(24'h000500, 1'b0);
      send(24'h000300, 1'b0);
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("mid_rst_vld", 32'(bus.out_valid), 32'd0);
      chk("mid_rst_sum", 32'(bus.sum), 32'd0);
      send(24'h000100, 1'b1);
      expect_result("post_rst", 24'h000100, 8'd1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
